// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Holds the FSM state encoding and frame field widths.
// Imported by the interface-facing top module.
package prog_loader_pkg;

  localparam int FRAME_LEN_BYTES = 2;
  localparam int CKSUM_W         = 8;
  localparam int LEN_W           = 8 * FRAME_LEN_BYTES;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CKSUM,
    S_DONE,
    S_ERROR
  } loader_state_t;

  // States from which a start request begins a new frame.
  function automatic logic is_restartable(input loader_state_t s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instmem write port of the program loader.
// Pure wiring, no latency.
// Stream side is valid/ready; the write port has no backpressure.
interface prog_loader_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic              mem_we;

  // Loader side: consumes the byte stream, drives the instmem write port.
  modport master (
    input  in_valid, in_data,
    output in_ready, mem_waddr, mem_wdata, mem_we
  );

  // Environment side: byte source and instmem.
  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_waddr, mem_wdata, mem_we
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed program (LEN, words, XOR checksum) into instmem, holds CPU until verified.
// One byte per cycle when streaming; each word adds a 1-cycle WRITE, so 1 word per 3 cycles.
// Stalls indefinitely on in_valid=0; in_ready is low outside byte-accepting states.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                MAX_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_loaded
);

  loader_state_t      state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         hi_q, hi_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [CKSUM_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               hold_q, hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic [LEN_W-1:0]   new_len;
  logic [LEN_W-1:0]   cnt_inc;

  // Ready depends only on state so the source never sees a combinational loop.
  always_comb begin
    bus.in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                   (state_q == S_CKSUM);
  end

  assign accept  = bus.in_valid & bus.in_ready;
  assign new_len = {len_q[LEN_W-1:8], bus.in_data};
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;

    if (is_restartable(state_q)) begin
      if (start) begin
        state_d = S_LEN_HI;
        cnt_d   = '0;
        acc_d   = '0;
        hold_d  = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_LEN_HI: if (accept) begin
          len_d[LEN_W-1:8] = bus.in_data;
          acc_d            = acc_q ^ bus.in_data;
          state_d          = S_LEN_LO;
        end
        S_LEN_LO: if (accept) begin
          len_d = new_len;
          acc_d = acc_q ^ bus.in_data;
          if (new_len == '0) begin
            state_d = S_CKSUM;
          end else if (new_len > LEN_W'(MAX_WORDS)) begin
            // Oversized frame: reject before touching instmem.
            state_d = S_ERROR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        S_DATA_HI: if (accept) begin
          hi_d    = bus.in_data;
          acc_d   = acc_q ^ bus.in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: if (accept) begin
          wdata_d = {hi_q, bus.in_data};
          waddr_d = BASE_ADDR + ADDR_W'(cnt_q);
          acc_d   = acc_q ^ bus.in_data;
          we_d    = 1'b1;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? S_CKSUM : S_DATA_HI;
        end
        S_CKSUM: if (accept) begin
          busy_d = 1'b0;
          if (bus.in_data == acc_q) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            hold_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset aborts any frame and keeps the CPU held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign cpu_hold      = hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_loaded  = ADDR_W'(cnt_q);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of frames plus reset and restart sequences.
// Writes are captured by a monitor and compared against hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cpu_hold, busy, done, err;
  logic [15:0] words_loaded;

  prog_loader_if #(.ADDR_W(16)) bus ();

  prog_loader #(.ADDR_W(16), .MAX_WORDS(1024), .BASE_ADDR(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  int cyc   = 0;
  logic [15:0] wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];

  // Capture every instmem write and watch the always-true invariants.
  always @(negedge clk) begin
    cyc++;
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_waddr);
      wd_q.push_back(bus.mem_wdata);
      wc_q.push_back(cyc);
    end
    if (bus.mem_we && bus.in_ready) viol++;
    if (done && err) viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k = 0;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [63:0] bytes;   // first frame byte in the top 8 bits
    int          n;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int          exp_wl;
    int          nw;
    logic [15:0] wa0, wd0, wa1, wd1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Two-word frame: 00^02^12^34^AB^CD = 42.
    vecs[0] = '{"two_words",  64'h0002_1234_ABCD_4200, 7, 1'b0, 1'b1, 1'b0, 2, 2,
                16'h0000, 16'h1234, 16'h0001, 16'hABCD};
    vecs[1] = '{"bad_cksum",  64'h0002_1234_ABCD_FF00, 7, 1'b0, 1'b0, 1'b1, 2, 2,
                16'h0000, 16'h1234, 16'h0001, 16'hABCD};
    vecs[2] = '{"len_1025",   64'h0401_0000_0000_0000, 2, 1'b0, 1'b0, 1'b1, 0, 0,
                16'h0, 16'h0, 16'h0, 16'h0};
    vecs[3] = '{"len_zero",   64'h0000_0000_0000_0000, 3, 1'b0, 1'b1, 1'b0, 0, 0,
                16'h0, 16'h0, 16'h0, 16'h0};
    vecs[4] = '{"gappy",      64'h0002_1234_ABCD_4200, 7, 1'b1, 1'b1, 1'b0, 2, 2,
                16'h0000, 16'h1234, 16'h0001, 16'hABCD};
    // One word: 00^01^BE^EF = 50.
    vecs[5] = '{"one_word",   64'h0001_BEEF_5000_0000, 5, 1'b0, 1'b1, 1'b0, 1, 1,
                16'h0000, 16'hBEEF, 16'h0, 16'h0};

    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("rst_waddr", 32'(bus.mem_waddr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    rst = 1'b1;

    // Abort mid-DATA_LO: LEN=1024 is legal, so the loader reaches DATA_LO.
    start_pulse();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("max_len_busy", 32'(busy), 32'd1);
    chk("max_len_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_hold", 32'(cpu_hold), 32'd1);
    chk("abort_we", 32'(bus.mem_we), 32'd0);
    chk("abort_flags", {29'd0, busy, done, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_ready", 32'(bus.in_ready), 32'd0);
    chk("post_abort_hold", 32'(cpu_hold), 32'd1);

    // Table of frames, each started from DONE/ERROR/IDLE of the previous one.
    for (int i = 0; i < 6; i++) begin
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      start_pulse();
      chk({vecs[i].name, "_start_flags"}, {28'd0, cpu_hold, busy, done, err}, 32'b1100);
      for (int j = 0; j < vecs[i].n; j++) begin
        logic [63:0] bb;
        bb = vecs[i].bytes << (8 * j);
        send_byte(bb[63:56], vecs[i].gaps);
      end
      chk({vecs[i].name, "_done"}, 32'(done), 32'(vecs[i].exp_done));
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      chk({vecs[i].name, "_hold"}, 32'(cpu_hold), 32'(!vecs[i].exp_done));
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
      chk({vecs[i].name, "_ready"}, 32'(bus.in_ready), 32'd0);
      chk({vecs[i].name, "_wl"}, 32'(words_loaded), 32'(vecs[i].exp_wl));
      chk({vecs[i].name, "_nwrites"}, 32'(wa_q.size()), 32'(vecs[i].nw));
      if (vecs[i].nw >= 1 && wa_q.size() >= 1) begin
        chk({vecs[i].name, "_wa0"}, 32'(wa_q[0]), 32'(vecs[i].wa0));
        chk({vecs[i].name, "_wd0"}, 32'(wd_q[0]), 32'(vecs[i].wd0));
      end
      if (vecs[i].nw >= 2 && wa_q.size() >= 2) begin
        chk({vecs[i].name, "_wa1"}, 32'(wa_q[1]), 32'(vecs[i].wa1));
        chk({vecs[i].name, "_wd1"}, 32'(wd_q[1]), 32'(vecs[i].wd1));
        if (!vecs[i].gaps)
          chk({vecs[i].name, "_spacing"}, 32'(wc_q[1] - wc_q[0]), 32'd3);
      end
    end

    // Restart after DONE, with start pulses during the frame that must be ignored.
    wa_q.delete();
    wd_q.delete();
    start_pulse();
    chk("restart_done_clr", 32'(done), 32'd0);
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_wl", 32'(words_loaded), 32'd0);
    send_byte(8'h00, 1'b0);
    start = 1'b1;
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hAB, 1'b0);
    start = 1'b1;
    send_byte(8'hCD, 1'b0);
    start = 1'b0;
    send_byte(8'h42, 1'b0);
    chk("busy_start_done", 32'(done), 32'd1);
    chk("busy_start_wl", 32'(words_loaded), 32'd2);
    chk("busy_start_nw", 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      chk("busy_start_wa0", 32'(wa_q[0]), 32'h0000);
      chk("busy_start_wd1", 32'(wd_q[1]), 32'hABCD);
    end

    @(negedge clk);
    chk("invariants", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
